// File: rtl/shot_link_ctl.sv
// rtl/shot_link_ctl.sv - two-byte SHOT/RESULT frame engine between game FSM and UART
// Optional feature: define SHOT_LINK_TIMEOUT_EN to enable the reply-wait timeout.
module shot_link_ctl #(
  parameter int unsigned TIMEOUT_CYC = 32'd65_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       addres_sent,
  input  logic [7:0] check_out,
  output logic [1:0] msg_in,
  output logic [7:0] check_in,
  output logic       shot_valid,
  input  logic [1:0] local_result,
  input  logic       local_result_valid,
  output logic [1:0] msg_send,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       link_err
);

  localparam logic [7:0] HDR_SHOT = 8'hA5;
  localparam logic [7:0] HDR_RES  = 8'h5A;

  typedef enum logic [2:0] {
    S_IDLE, S_SHOT_HDR, S_SHOT_PAY, S_WAIT_RES, S_LOOKUP, S_RES_HDR, S_RES_PAY
  } state_t;

  typedef enum logic {RX_HDR, RX_PAY} rx_state_t;

  state_t    r_state;
  rx_state_t r_rx_state;
  logic      r_rx_is_shot;
  logic      r_as_d1, r_as_d2;
  logic [7:0] r_shot_addr;
  logic [1:0] r_verdict;
  logic [1:0] r_msg_in, r_msg_send;
  logic [7:0] r_check_in, r_tx_data;
  logic       r_shot_valid, r_tx_valid, r_link_err;
`ifdef SHOT_LINK_TIMEOUT_EN
  logic [31:0] r_to_cnt;
  logic        w_to_hit;
`endif

  logic       w_req_edge;
  logic       w_rx_frame, w_shot_frm, w_res_frm;
  logic       w_tx_fire;
  logic       w_res_ok;
  logic [1:0] w_local_verdict;

  // The request edge is taken between two registered copies, giving the two-cycle start latency
  assign w_req_edge      = r_as_d1 & ~r_as_d2;
  assign w_rx_frame      = (r_rx_state == RX_PAY) && rx_valid;
  assign w_shot_frm      = w_rx_frame && r_rx_is_shot;
  assign w_res_frm       = w_rx_frame && !r_rx_is_shot;
  assign w_tx_fire       = r_tx_valid && tx_ready;
  assign w_res_ok        = (rx_data[1:0] == 2'b01) || (rx_data[1:0] == 2'b10);
  // Anything other than an explicit hit is reported as a miss
  assign w_local_verdict = (local_result == 2'b10) ? 2'b10 : 2'b01;
`ifdef SHOT_LINK_TIMEOUT_EN
  assign w_to_hit        = (r_to_cnt == TIMEOUT_CYC - 32'd1);
`endif

  assign msg_in     = r_msg_in;
  assign msg_send   = r_msg_send;
  assign check_in   = r_check_in;
  assign shot_valid = r_shot_valid;
  assign tx_data    = r_tx_data;
  assign tx_valid   = r_tx_valid;
  assign link_err   = r_link_err;

  // Register the shot request level for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_as_d1 <= 1'b0;
      r_as_d2 <= 1'b0;
    end else begin
      r_as_d1 <= addres_sent;
      r_as_d2 <= r_as_d1;
    end
  end

  // Receive parser: find a header, then deliver the next byte as that frame's payload
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_state   <= RX_HDR;
      r_rx_is_shot <= 1'b0;
    end else if (rx_valid) begin
      if (r_rx_state == RX_HDR) begin
        if (rx_data == HDR_SHOT) begin
          r_rx_state   <= RX_PAY;
          r_rx_is_shot <= 1'b1;
        end else if (rx_data == HDR_RES) begin
          r_rx_state   <= RX_PAY;
          r_rx_is_shot <= 1'b0;
        end
      end else begin
        r_rx_state <= RX_HDR;
      end
    end
  end

  // Main protocol FSM with registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_shot_addr  <= 8'h00;
      r_verdict    <= 2'b00;
      r_msg_in     <= 2'b00;
      r_msg_send   <= 2'b00;
      r_check_in   <= 8'h00;
      r_shot_valid <= 1'b0;
      r_tx_data    <= 8'h00;
      r_tx_valid   <= 1'b0;
      r_link_err   <= 1'b0;
`ifdef SHOT_LINK_TIMEOUT_EN
      r_to_cnt     <= 32'd0;
`endif
    end else begin
      r_shot_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // An incoming shot takes priority; a simultaneous request edge is dropped
          if (w_shot_frm) begin
            r_check_in   <= rx_data;
            r_shot_valid <= 1'b1;
            r_msg_in     <= 2'b00;
            r_state      <= S_LOOKUP;
`ifdef SHOT_LINK_TIMEOUT_EN
            r_to_cnt     <= 32'd0;
`endif
          end else if (w_req_edge) begin
            r_shot_addr <= check_out;
            r_msg_send  <= 2'b00;
            r_tx_valid  <= 1'b1;
            r_tx_data   <= HDR_SHOT;
            r_state     <= S_SHOT_HDR;
          end
        end
        S_SHOT_HDR: begin
          if (w_tx_fire) begin
            r_tx_data <= r_shot_addr;
            r_state   <= S_SHOT_PAY;
          end
        end
        S_SHOT_PAY: begin
          if (w_tx_fire) begin
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'h00;
            r_state    <= S_WAIT_RES;
`ifdef SHOT_LINK_TIMEOUT_EN
            r_to_cnt   <= 32'd0;
`endif
          end
        end
        S_WAIT_RES: begin
          if (w_res_frm && w_res_ok) begin
            r_msg_in <= rx_data[1:0];
            r_state  <= S_IDLE;
          end
`ifdef SHOT_LINK_TIMEOUT_EN
          else if (w_to_hit) begin
            r_link_err <= 1'b1;
            r_msg_in   <= 2'b01;
            r_state    <= S_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 32'd1;
          end
`endif
        end
        S_LOOKUP: begin
          if (local_result_valid) begin
            r_verdict  <= w_local_verdict;
            r_tx_valid <= 1'b1;
            r_tx_data  <= HDR_RES;
            r_state    <= S_RES_HDR;
          end
`ifdef SHOT_LINK_TIMEOUT_EN
          else if (w_to_hit) begin
            r_link_err <= 1'b1;
            r_msg_in   <= 2'b01;
            r_state    <= S_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 32'd1;
          end
`endif
        end
        S_RES_HDR: begin
          if (w_tx_fire) begin
            r_tx_data <= {6'b0, r_verdict};
            r_state   <= S_RES_PAY;
          end
        end
        S_RES_PAY: begin
          if (w_tx_fire) begin
            r_msg_send <= r_verdict;
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'h00;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      // Frames arriving in a state that cannot use them are dropped and flagged
      if (w_shot_frm && (r_state != S_IDLE))
        r_link_err <= 1'b1;
      if (w_res_frm && (r_state != S_WAIT_RES))
        r_link_err <= 1'b1;
    end
  end

endmodule
